// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit/vend controller.
package vend_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  // Coin face values in credit units
  localparam int V_N = 5;
  localparam int V_D = 10;
  localparam int V_Q = 25;

  // Default value returned per change pulse
  localparam int CHG_UNIT_DEF = 5;

endpackage

// File: rtl/vend_if.sv
// Customer-facing bus of the vend controller: coin/select/cancel in,
// dispense/change/reject/status out.
interface vend_if #(
  parameter int CW = 6
);
  logic          N;
  logic          D;
  logic          Q;
  logic          Sel;
  logic          Cancel;
  logic          En;
  logic          Chg;
  logic          Rej;
  logic          Busy;
  logic [CW-1:0] Credit;

  // Coin acceptor / front panel side
  modport master (
    output N, D, Q, Sel, Cancel,
    input  En, Chg, Rej, Busy, Credit
  );

  // Controller side
  modport slave (
    input  N, D, Q, Sel, Cancel,
    output En, Chg, Rej, Busy, Credit
  );
endinterface

// File: rtl/vend_coin_decode.sv
// Coin pulse decoder: picks the highest-value coin of a cycle and flags
// any extra coins presented alongside it so they can be rejected.
module coin_decode
  import vend_pkg::*;
#(
  parameter int CW = 6
) (
  input  logic          n,
  input  logic          d,
  input  logic          q,
  output logic [CW-1:0] val,
  output logic          vld,
  output logic          multi
);

  // Priority select Q > D > N; more than one coin means the losers bounce
  always_comb begin
    val   = '0;
    vld   = n | d | q;
    multi = (q & (d | n)) | (d & n);
    if (q)      val = CW'(V_Q);
    else if (d) val = CW'(V_D);
    else if (n) val = CW'(V_N);
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending credit/vend controller. Accumulates coin credit, drives En to
// the dispense stage for DISP_CYC cycles on a paid selection, then pays
// back remaining credit one CHG_UNIT per cycle. All outputs registered.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CW       = 6,
  parameter int PRICE    = 15,
  parameter int MAXCRED  = 60,
  parameter int DISP_CYC = 2,
  parameter int CHG_UNIT = CHG_UNIT_DEF
) (
  input  logic   CLK,
  input  logic   RST,
  vend_if.slave  bus
);

  localparam int              CNTW     = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(DISP_CYC - 1);
  localparam logic [CW:0]     MAX_W    = (CW+1)'(MAXCRED);
  localparam logic [CW-1:0]   PRICE_W  = CW'(PRICE);
  localparam logic [CW-1:0]   CHG_W    = CW'(CHG_UNIT);

  state_t          state_q, state_n;
  logic [CW-1:0]   credit_q, credit_n;
  logic [CNTW-1:0] cnt_q, cnt_n;
  logic            en_q, en_n;
  logic            chg_q, chg_n;
  logic            rej_q, rej_n;
  logic            busy_q, busy_n;

  logic [CW-1:0]   coin_val;
  logic            coin_vld;
  logic            coin_multi;
  logic [CW:0]     sum;
  logic            accept;
  logic [CW-1:0]   cred_add;

  coin_decode #(.CW(CW)) u_dec (
    .n     (bus.N),
    .d     (bus.D),
    .q     (bus.Q),
    .val   (coin_val),
    .vld   (coin_vld),
    .multi (coin_multi)
  );

  // One extra bit so a coin that overshoots the ceiling is caught, not wrapped
  assign sum      = {1'b0, credit_q} + {1'b0, coin_val};
  assign accept   = coin_vld && (sum <= MAX_W);
  assign cred_add = accept ? sum[CW-1:0] : credit_q;

  // Next-state, next-credit and next-output decision
  always_comb begin
    state_n  = state_q;
    credit_n = credit_q;
    cnt_n    = cnt_q;
    rej_n    = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        rej_n    = coin_multi | (coin_vld & ~accept);
        credit_n = cred_add;
        state_n  = (cred_add != '0) ? S_COLLECT : S_IDLE;
        // Coin lands first; selection is judged on the updated credit
        if (state_q == S_COLLECT && bus.Sel && cred_add >= PRICE_W) begin
          state_n  = S_VEND;
          credit_n = cred_add - PRICE_W;
          cnt_n    = CNT_INIT;
        end else if (state_q == S_COLLECT && bus.Cancel) begin
          // First change coin goes out on entry, hence the immediate debit
          state_n  = S_CHANGE;
          credit_n = cred_add - CHG_W;
        end
      end
      S_VEND: begin
        rej_n = coin_vld;
        if (cnt_q != '0) begin
          cnt_n = cnt_q - 1'b1;
        end else if (credit_q != '0) begin
          state_n  = S_CHANGE;
          credit_n = credit_q - CHG_W;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_CHANGE: begin
        rej_n = coin_vld;
        if (credit_q != '0) credit_n = credit_q - CHG_W;
        else                state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    en_n   = (state_n == S_VEND);
    chg_n  = (state_n == S_CHANGE);
    busy_n = en_n | chg_n;
  end

  // State, credit, dispense counter and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      chg_q    <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      credit_q <= credit_n;
      cnt_q    <= cnt_n;
      en_q     <= en_n;
      chg_q    <= chg_n;
      rej_q    <= rej_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.En     = en_q;
  assign bus.Chg    = chg_q;
  assign bus.Rej    = rej_q;
  assign bus.Busy   = busy_q;
  assign bus.Credit = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: reset, exact pay, overpay with change,
// ceiling/multi-coin rejects, cancel refund, and reset in mid-vend.
module tb_vend_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  vend_if #(.CW(6)) bus();

  vend_ctrl #(
    .CW(6), .PRICE(15), .MAXCRED(60), .DISP_CYC(2), .CHG_UNIT(5)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic chg,
                         input logic rej, input logic busy, input int credit);
    chk({tag, ".En"},     {31'd0, bus.En},   {31'd0, en});
    chk({tag, ".Chg"},    {31'd0, bus.Chg},  {31'd0, chg});
    chk({tag, ".Rej"},    {31'd0, bus.Rej},  {31'd0, rej});
    chk({tag, ".Busy"},   {31'd0, bus.Busy}, {31'd0, busy});
    chk({tag, ".Credit"}, {26'd0, bus.Credit}, 32'(credit));
  endtask

  task automatic idle_in();
    bus.N = 0; bus.D = 0; bus.Q = 0; bus.Sel = 0; bus.Cancel = 0;
  endtask

  initial begin
    idle_in();
    // Reset hold with coins toggling
    RST = 1;
    for (int i = 0; i < 3; i++) begin
      bus.N = i[0]; bus.D = ~i[0]; bus.Q = 1'b1; bus.Sel = 1'b1;
      tick();
      chk_all("rst_hold", 0, 0, 0, 0, 0);
    end
    idle_in(); RST = 0;
    tick();
    chk_all("rst_rel", 0, 0, 0, 0, 0);

    // Exact price: D, N, Sel
    bus.D = 1; tick(); idle_in(); chk_all("exact_d", 0, 0, 0, 0, 10);
    bus.N = 1; tick(); idle_in(); chk_all("exact_n", 0, 0, 0, 0, 15);
    bus.Sel = 1; tick(); idle_in(); chk_all("exact_en1", 1, 0, 0, 1, 0);
    tick(); chk_all("exact_en2", 1, 0, 0, 1, 0);
    tick(); chk_all("exact_idle", 0, 0, 0, 0, 0);
    tick(); chk_all("exact_nochg", 0, 0, 0, 0, 0);

    // Overpay: Q, Sel -> vend, then two change pulses
    bus.Q = 1; tick(); idle_in(); chk_all("over_q", 0, 0, 0, 0, 25);
    bus.Sel = 1; tick(); idle_in(); chk_all("over_en1", 1, 0, 0, 1, 10);
    tick(); chk_all("over_en2", 1, 0, 0, 1, 10);
    tick(); chk_all("over_chg1", 0, 1, 0, 1, 5);
    tick(); chk_all("over_chg2", 0, 1, 0, 1, 0);
    tick(); chk_all("over_idle", 0, 0, 0, 0, 0);

    // Ceiling and multi-coin conflicts
    bus.Q = 1; tick(); idle_in(); chk_all("ovf_q1", 0, 0, 0, 0, 25);
    bus.Q = 1; tick(); idle_in(); chk_all("ovf_q2", 0, 0, 0, 0, 50);
    bus.Q = 1; tick(); idle_in(); chk_all("ovf_q3_rej", 0, 0, 1, 0, 50);
    tick(); chk_all("ovf_rej_pulse", 0, 0, 0, 0, 50);
    bus.N = 1; bus.D = 1; tick(); idle_in(); chk_all("ovf_nd", 0, 0, 1, 0, 60);
    bus.D = 1; tick(); idle_in(); chk_all("ovf_full_d", 0, 0, 1, 0, 60);
    RST = 1; tick(); RST = 0; chk_all("ovf_rst", 0, 0, 0, 0, 0);

    // Cancel refund, coin during change is bounced
    bus.N = 1; tick(); idle_in(); chk_all("can_n1", 0, 0, 0, 0, 5);
    bus.N = 1; tick(); idle_in(); chk_all("can_n2", 0, 0, 0, 0, 10);
    bus.Cancel = 1; tick(); idle_in(); chk_all("can_chg1", 0, 1, 0, 1, 5);
    bus.Q = 1; tick(); idle_in(); chk_all("can_chg2_rej", 0, 1, 1, 1, 0);
    tick(); chk_all("can_idle", 0, 0, 0, 0, 0);

    // Coin and Sel together: coin counts first; Cancel loses to Sel
    bus.N = 1; tick(); idle_in(); chk_all("cs_n", 0, 0, 0, 0, 5);
    bus.D = 1; bus.Sel = 1; bus.Cancel = 1; tick(); idle_in();
    chk_all("cs_en1", 1, 0, 0, 1, 0);
    tick(); chk_all("cs_en2", 1, 0, 0, 1, 0);
    tick(); chk_all("cs_idle", 0, 0, 0, 0, 0);

    // Reset in first En cycle; Sel in IDLE ignored afterwards
    bus.Q = 1; tick(); idle_in(); chk_all("rv_q", 0, 0, 0, 0, 25);
    bus.Sel = 1; tick(); idle_in(); chk_all("rv_en1", 1, 0, 0, 1, 10);
    RST = 1; tick(); RST = 0; chk_all("rv_rst", 0, 0, 0, 0, 0);
    bus.Sel = 1; tick(); idle_in(); chk_all("rv_sel_idle", 0, 0, 0, 0, 0);
    bus.Cancel = 1; tick(); idle_in(); chk_all("rv_cancel_idle", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
